// File: rtl/led_fade_pwm.sv
// led_fade_pwm: renders a 16-bit on/off LED pattern as per-channel PWM
// brightness. A lit channel glows at BRIGHT. A channel whose input drops
// fades out linearly, one level per decay tick, which gives a trailing glow.
//
// Ports:
//   CLK       system clock (the only clock)
//   RESET     synchronous, active-high reset
//   LED_IN    [N_LED]   pattern from the upstream generator, treated as async
//   BRIGHT    [LEVEL_W] level loaded into channels whose input is 1
//   LED_OUT   [N_LED]   registered PWM drive
//   PWM_SYNC  1-cycle registered pulse when the PWM step counter wraps

// Per-channel level register and PWM comparator.
module led_fade_chan #(
   parameter int LEVEL_W = 4
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic               in_bit,
   input  logic               decay_tick,
   input  logic [LEVEL_W-1:0] bright,
   input  logic [LEVEL_W-1:0] pwm_cnt,
   output logic               led
);
   logic [LEVEL_W-1:0] level;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         level <= '0;
         led   <= 1'b0;
      end else begin
         // A high input always wins, even on a decay tick.
         if (in_bit)
            level <= bright;
         else if (decay_tick && (level != '0))
            level <= level - LEVEL_W'(1);
         // pwm_cnt never reaches all-ones, so the top level is always on.
         led <= (level > pwm_cnt);
      end
   end
endmodule

module led_fade_pwm #(
   parameter int N_LED     = 16,
   parameter int LEVEL_W   = 4,
   parameter int PWM_DIV   = 64,
   parameter int DECAY_DIV = 400000
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic [N_LED-1:0]   LED_IN,
   input  logic [LEVEL_W-1:0] BRIGHT,
   output logic [N_LED-1:0]   LED_OUT,
   output logic               PWM_SYNC
);
   // Keep counters at least one bit wide so DIV=1 still elaborates.
   localparam int PRE_W = (PWM_DIV   > 1) ? $clog2(PWM_DIV)   : 1;
   localparam int DEC_W = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
   localparam logic [PRE_W-1:0]   PRE_MAX = PRE_W'(PWM_DIV - 1);
   localparam logic [DEC_W-1:0]   DEC_MAX = DEC_W'(DECAY_DIV - 1);
   localparam logic [LEVEL_W-1:0] CNT_MAX = LEVEL_W'((1 << LEVEL_W) - 2);

   logic [N_LED-1:0]   s1, s2;
   logic [PRE_W-1:0]   pwm_pre;
   logic [LEVEL_W-1:0] pwm_cnt;
   logic [DEC_W-1:0]   decay_pre;
   logic               pwm_step, decay_tick;

   assign pwm_step   = (pwm_pre   == PRE_MAX);
   assign decay_tick = (decay_pre == DEC_MAX);

   // Two-flop synchroniser; only s2 is used downstream.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= LED_IN;
         s2 <= s1;
      end
   end

   // PWM prescaler and step counter. The counter period is 2^LEVEL_W-1
   // steps so that level L gives exactly L of every period high.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         pwm_pre  <= '0;
         pwm_cnt  <= '0;
         PWM_SYNC <= 1'b0;
      end else begin
         pwm_pre  <= pwm_step ? '0 : pwm_pre + PRE_W'(1);
         PWM_SYNC <= pwm_step && (pwm_cnt == CNT_MAX);
         if (pwm_step)
            pwm_cnt <= (pwm_cnt == CNT_MAX) ? '0 : pwm_cnt + LEVEL_W'(1);
      end
   end

   // Free-running fade prescaler, independent of the PWM timing.
   always_ff @(posedge CLK) begin
      if (RESET)
         decay_pre <= '0;
      else
         decay_pre <= decay_tick ? '0 : decay_pre + DEC_W'(1);
   end

   for (genvar i = 0; i < N_LED; i++) begin : g_chan
      led_fade_chan #(.LEVEL_W(LEVEL_W)) u_chan (
         .CLK        (CLK),
         .RESET      (RESET),
         .in_bit     (s2[i]),
         .decay_tick (decay_tick),
         .bright     (BRIGHT),
         .pwm_cnt    (pwm_cnt),
         .led        (LED_OUT[i])
      );
   end
endmodule

// File: tb/tb_led_fade_pwm.sv
// Bench for led_fade_pwm with PWM_DIV=1, DECAY_DIV=4. A cycle-count based
// reference model pushes expected outputs per edge; a negedge scoreboard
// pops and compares. Scenario tasks add targeted checks on top.
module tb_led_fade_pwm;
   logic        CLK = 1'b0;
   logic        RESET;
   logic [15:0] LED_IN;
   logic [3:0]  BRIGHT;
   logic [15:0] LED_OUT;
   logic        PWM_SYNC;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [15:0] led;
      logic        sync;
   } exp_t;
   exp_t exp_q[$];

   // Reference model state: m_t counts edges since reset release.
   int          m_t;
   logic [15:0] m_s1, m_s2;
   int          m_lvl[16];

   led_fade_pwm #(.N_LED(16), .LEVEL_W(4), .PWM_DIV(1), .DECAY_DIV(4)) dut (
      .CLK      (CLK),
      .RESET    (RESET),
      .LED_IN   (LED_IN),
      .BRIGHT   (BRIGHT),
      .LED_OUT  (LED_OUT),
      .PWM_SYNC (PWM_SYNC)
   );

   always #5 CLK = ~CLK;

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1);
   end

   // Model: PWM step every cycle, so pwm_cnt before edge t is t mod 15 and
   // a decay tick happens on edges with t mod 4 == 3.
   always @(posedge CLK) begin
      exp_t e;
      int   pc;
      if (RESET) begin
         m_t = 0; m_s1 = '0; m_s2 = '0;
         foreach (m_lvl[i]) m_lvl[i] = 0;
         e.led = '0; e.sync = 1'b0;
      end else begin
         pc = m_t % 15;
         for (int i = 0; i < 16; i++) e.led[i] = (m_lvl[i] > pc);
         e.sync = (pc == 14);
         for (int i = 0; i < 16; i++) begin
            if (m_s2[i]) m_lvl[i] = int'(BRIGHT);
            else if ((m_t % 4) == 3 && m_lvl[i] > 0) m_lvl[i] = m_lvl[i] - 1;
         end
         m_s2 = m_s1; m_s1 = LED_IN; m_t++;
      end
      exp_q.push_back(e);
   end

   always @(negedge CLK) begin
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL sb_empty: got no expectation, required one per edge");
      end else begin
         e = exp_q.pop_front();
         if (LED_OUT !== e.led || PWM_SYNC !== e.sync) begin
            errors++;
            $display("FAIL sb_cycle t=%0t: LED_OUT=%h PWM_SYNC=%b, expected %h %b",
                     $time, LED_OUT, PWM_SYNC, e.led, e.sync);
         end
      end
   end

   // Wait (bounded) for a sync pulse, then count ch highs over one frame.
   task automatic measure_frame(input int ch, output int duty, output bit found);
      found = 1'b0; duty = 0;
      for (int k = 0; k < 40 && !found; k++) begin
         @(negedge CLK);
         if (PWM_SYNC === 1'b1) found = 1'b1;
      end
      for (int j = 1; j <= 15; j++) begin
         @(negedge CLK);
         if (LED_OUT[ch] === 1'b1) duty++;
      end
   endtask

   task automatic test_reset();
      int first, second;
      RESET = 1'b1; LED_IN = 16'hFFFF; BRIGHT = 4'd15;
      for (int k = 0; k < 3; k++) begin
         @(negedge CLK);
         checks++;
         if (LED_OUT !== 16'h0000 || PWM_SYNC !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: LED_OUT=%h PWM_SYNC=%b, expected 0000 0", LED_OUT, PWM_SYNC);
         end
      end
      RESET = 1'b0; LED_IN = 16'h0000;
      first = -1; second = -1;
      for (int j = 1; j <= 31; j++) begin
         @(negedge CLK);
         if (PWM_SYNC === 1'b1) begin
            if (first < 0) first = j;
            else if (second < 0) second = j;
         end
      end
      checks++;
      if (first != 15 || second != 30) begin
         errors++;
         $display("FAIL reset_sync_period: first=%0d second=%0d, expected 15 30", first, second);
      end
   endtask

   task automatic test_latency();
      BRIGHT = 4'd15; LED_IN = 16'h0001;
      for (int j = 0; j < 20; j++) begin
         @(negedge CLK);
         checks++;
         if (LED_OUT !== ((j >= 3) ? 16'h0001 : 16'h0000)) begin
            errors++;
            $display("FAIL latency j=%0d: LED_OUT=%h, expected %h", j, LED_OUT,
                     (j >= 3) ? 16'h0001 : 16'h0000);
         end
      end
   endtask

   task automatic test_duty();
      bit found;
      int duty;
      BRIGHT = 4'd8; LED_IN = 16'h0002;
      repeat (6) @(negedge CLK);
      found = 1'b0;
      for (int k = 0; k < 40 && !found; k++) begin
         @(negedge CLK);
         if (PWM_SYNC === 1'b1) found = 1'b1;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL duty_sync: got no PWM_SYNC, expected one within 40 cycles");
      end
      duty = 0;
      for (int j = 1; j <= 15; j++) begin
         @(negedge CLK);
         if (LED_OUT[1] === 1'b1) duty++;
         checks++;
         if (LED_OUT[1] !== (j <= 8)) begin
            errors++;
            $display("FAIL duty8 j=%0d: LED_OUT[1]=%b, expected %b", j, LED_OUT[1], (j <= 8));
         end
      end
      checks++;
      if (duty != 8) begin
         errors++;
         $display("FAIL duty8_count: got %0d, expected 8", duty);
      end
      BRIGHT = 4'd0;
      measure_frame(1, duty, found);
      checks++;
      if (!found || duty != 0) begin
         errors++;
         $display("FAIL duty0: found=%b duty=%0d, expected 1 0", found, duty);
      end
   endtask

   task automatic test_fade();
      int  d[8];
      bit  found, partial;
      BRIGHT = 4'd15; LED_IN = 16'h0004;
      repeat (8) @(negedge CLK);
      LED_IN = 16'h0000;
      found = 1'b0;
      for (int k = 0; k < 40 && !found; k++) begin
         @(negedge CLK);
         if (PWM_SYNC === 1'b1) found = 1'b1;
      end
      for (int f = 0; f < 8; f++) begin
         d[f] = 0;
         for (int j = 1; j <= 15; j++) begin
            @(negedge CLK);
            if (LED_OUT[2] === 1'b1) d[f]++;
         end
      end
      partial = 1'b0;
      for (int f = 0; f < 8; f++) if (d[f] > 0 && d[f] < 15) partial = 1'b1;
      checks++;
      if (!found || !partial) begin
         errors++;
         $display("FAIL fade_linear: found=%b partial=%b, expected 1 1", found, partial);
      end
      for (int f = 1; f < 8; f++) begin
         checks++;
         if (d[f] > d[f-1]) begin
            errors++;
            $display("FAIL fade_monotonic f=%0d: duty %0d after %0d, expected <=", f, d[f], d[f-1]);
         end
      end
      checks++;
      if (d[6] != 0 || d[7] != 0) begin
         errors++;
         $display("FAIL fade_floor: duty %0d %0d, expected 0 0", d[6], d[7]);
      end
   endtask

   task automatic test_retrigger();
      bit found, aligned;
      int duty;
      // Mid-fade retrigger on channel 3.
      BRIGHT = 4'd6; LED_IN = 16'h0008;
      repeat (6) @(negedge CLK);
      LED_IN = 16'h0000;
      repeat (2) @(negedge CLK);
      BRIGHT = 4'd12; LED_IN = 16'h0008;
      measure_frame(3, duty, found);
      checks++;
      if (!found || duty != 12) begin
         errors++;
         $display("FAIL retrigger: found=%b duty=%0d, expected 1 12", found, duty);
      end
      // Collision on channel 4: first high level update lands on a decay tick,
      // and the following output samples a pwm_cnt that separates 12 from 4.
      BRIGHT = 4'd5; LED_IN = 16'h0010;
      repeat (6) @(negedge CLK);
      LED_IN = 16'h0000;
      repeat (2) @(negedge CLK);
      aligned = 1'b0;
      for (int k = 0; k < 80 && !aligned; k++) begin
         if ((m_t % 4) == 1 && ((m_t + 3) % 15) >= 4 && ((m_t + 3) % 15) <= 11) aligned = 1'b1;
         else @(negedge CLK);
      end
      BRIGHT = 4'd12; LED_IN = 16'h0010;
      repeat (4) @(negedge CLK);
      checks++;
      if (!aligned || LED_OUT[4] !== 1'b1) begin
         errors++;
         $display("FAIL collision: aligned=%b LED_OUT[4]=%b, expected 1 1", aligned, LED_OUT[4]);
      end
      measure_frame(4, duty, found);
      checks++;
      if (!found || duty != 12) begin
         errors++;
         $display("FAIL collision_duty: found=%b duty=%0d, expected 1 12", found, duty);
      end
   endtask

   task automatic test_reset_mid();
      BRIGHT = 4'd15; LED_IN = 16'hFFFF;
      repeat (8) @(negedge CLK);
      LED_IN = 16'h0000;
      repeat (5) @(negedge CLK);
      RESET = 1'b1;
      @(negedge CLK);
      checks++;
      if (LED_OUT !== 16'h0000 || PWM_SYNC !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid: LED_OUT=%h PWM_SYNC=%b, expected 0000 0", LED_OUT, PWM_SYNC);
      end
      RESET = 1'b0;
      for (int j = 1; j <= 20; j++) begin
         @(negedge CLK);
         checks++;
         if (LED_OUT !== 16'h0000 || PWM_SYNC !== (j == 15)) begin
            errors++;
            $display("FAIL reset_mid_after j=%0d: LED_OUT=%h PWM_SYNC=%b, expected 0000 %b",
                     j, LED_OUT, PWM_SYNC, (j == 15));
         end
      end
      LED_IN = 16'hFFFF;
      for (int j = 0; j < 6; j++) begin
         @(negedge CLK);
         checks++;
         if (LED_OUT !== ((j >= 3) ? 16'hFFFF : 16'h0000)) begin
            errors++;
            $display("FAIL reset_mid_relight j=%0d: LED_OUT=%h, expected %h", j, LED_OUT,
                     (j >= 3) ? 16'hFFFF : 16'h0000);
         end
      end
   endtask

   initial begin
      RESET = 1'b1; LED_IN = 16'hFFFF; BRIGHT = 4'd15;
      test_reset();
      test_latency();
      test_duty();
      test_fade();
      test_retrigger();
      test_reset_mid();
      repeat (2) @(negedge CLK);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
